// File: rtl/seq_alu.sv
// Registered ALU with a multi-cycle shift-add unsigned multiplier.
// Non-MUL ops complete in one cycle; MUL iterates one partial product per cycle.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             _iStart,
    input  logic [3:0]       _iOp,
    input  logic [WIDTH-1:0] _iA,
    input  logic [WIDTH-1:0] _iB,
    input  logic             _iC,
    output logic             _oBusy,
    output logic             _oDone,
    output logic [WIDTH-1:0] _oResult,
    output logic [WIDTH-1:0] _oResultHi,
    output logic             _oFlagCarry,
    output logic             _oFlagZero,
    output logic             _oFlagNeg
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_NOR = 4'd2, OP_NAND = 4'd3,
        OP_XOR = 4'd4, OP_XNOR = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
        OP_ROL = 4'd8, OP_ROR = 4'd9, OP_MUL = 4'd10
    } op_t;

    state_t             state, stateNext;
    logic [WIDTH-1:0]   mulA, accHi, accLo;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   aluR;
    logic               aluCarry, aluValid;
    logic [WIDTH:0]     addSum, subRhs, subDiff, mulSum;
    logic [WIDTH-1:0]   nextHi, nextLo;

    always_comb begin
        aluR     = '0;
        aluCarry = 1'b0;
        aluValid = 1'b1;
        addSum   = {1'b0, _iA} + {1'b0, _iB} + {{WIDTH{1'b0}}, _iC};
        subRhs   = {1'b0, _iB} + {{WIDTH{1'b0}}, _iC};
        // Bit WIDTH of the widened difference is set exactly when A < B+C.
        subDiff  = {1'b0, _iA} - subRhs;
        case (_iOp)
            OP_ADD:  begin aluR = addSum[WIDTH-1:0];  aluCarry = addSum[WIDTH];  end
            OP_SUB:  begin aluR = subDiff[WIDTH-1:0]; aluCarry = subDiff[WIDTH]; end
            OP_NOR:  aluR = ~(_iA | _iB);
            OP_NAND: aluR = ~(_iA & _iB);
            OP_XOR:  aluR = _iA ^ _iB;
            OP_XNOR: aluR = ~(_iA ^ _iB);
            OP_SHL:  begin aluR = {_iA[WIDTH-2:0], _iC};       aluCarry = _iA[WIDTH-1]; end
            OP_SHR:  begin aluR = {_iC, _iA[WIDTH-1:1]};       aluCarry = _iA[0];       end
            OP_ROL:  begin aluR = {_iA[WIDTH-2:0], _iA[WIDTH-1]}; aluCarry = _iA[WIDTH-1]; end
            OP_ROR:  begin aluR = {_iA[0], _iA[WIDTH-1:1]};    aluCarry = _iA[0];       end
            default: aluValid = 1'b0;
        endcase
    end

    always_comb begin
        mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, mulA} : '0);
        nextHi = mulSum[WIDTH:1];
        nextLo = {mulSum[0], accLo[WIDTH-1:1]};
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (_iStart) stateNext = (_iOp == OP_MUL) ? MUL_RUN : DONE;
            // Leave on the step that takes the counter from 1 to 0.
            MUL_RUN: if (cnt == CNT_W'(1)) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mulA        <= '0;
            accHi       <= '0;
            accLo       <= '0;
            cnt         <= '0;
            _oResult    <= '0;
            _oResultHi  <= '0;
            _oFlagCarry <= 1'b0;
            _oFlagZero  <= 1'b0;
            _oFlagNeg   <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: if (_iStart) begin
                    if (_iOp == OP_MUL) begin
                        mulA  <= _iA;
                        accHi <= '0;
                        accLo <= _iB;
                        cnt   <= CNT_W'(WIDTH);
                    end else if (aluValid) begin
                        _oResult    <= aluR;
                        _oResultHi  <= '0;
                        _oFlagCarry <= aluCarry;
                        _oFlagZero  <= (aluR == '0);
                        _oFlagNeg   <= aluR[WIDTH-1];
                    end
                end
                MUL_RUN: begin
                    accHi <= nextHi;
                    accLo <= nextLo;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        _oResult    <= nextLo;
                        _oResultHi  <= nextHi;
                        _oFlagCarry <= (nextHi != '0);
                        _oFlagZero  <= ({nextHi, nextLo} == '0);
                        _oFlagNeg   <= nextHi[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign _oBusy = (state == MUL_RUN);
    assign _oDone = (state == DONE);
endmodule
